fifo_stream_reader: RTL

- Read-side companion for fifo_sync.
- Pulls words out of the FIFO's read port and presents them on a valid/ready output stream.
- Tracks reads in flight across the FIFO read latency and absorbs them in a small internal skid buffer, so the FIFO is never over-read and no word is dropped under backpressure.
- Marks packet boundaries with m_last_o every PKT_LEN beats.

---
 rtl/fifo_stream_pkg.sv | 24 ++
 rtl/fifo_stream_reader_skid.sv | 61 ++++++
 rtl/fifo_stream_reader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared helpers for fifo_stream_reader: width functions and the in-flight popcount.
package fifo_stream_pkg;

    // Widest in-flight pipe the popcount handles; RD_LATENCY is at most 3.
    localparam int PIPE_MAX = 4;

    function automatic int cnt_w(input int skid_depth);
        return $clog2(skid_depth) + 1;
    endfunction

    function automatic int lvl_w(input int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic logic [2:0] popcount(input logic [PIPE_MAX-1:0] bits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < PIPE_MAX; i++) begin
            n = n + 3'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Circular skid buffer with a registered head word so the stream data comes straight from a flop.
module skid_buffer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SKID_DEPTH = 4,
    localparam int CNT_W = cnt_w(SKID_DEPTH),
    localparam int PTR_W = $clog2(SKID_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [CNT_W-1:0]      count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // The incoming word becomes the head when it lands in the slot the read pointer moves to.
        head_d = (push_i && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls words from a fifo_sync read port onto a valid/ready stream with packet marking.
// Optional beat/packet counters are built when FIFO_READER_BEATCNT_EN is defined.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 4,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 4,
    parameter int PKT_LEN    = 8
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  enable_i,
    input  logic [ADDR_BITS:0]    fifo_level_i,
    output logic                  fifo_rd_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  idle_o
`ifdef FIFO_READER_BEATCNT_EN
    ,
    output logic [31:0]           beat_count_o,
    output logic [15:0]           pkt_count_o
`endif
);

    localparam int CNT_W = cnt_w(SKID_DEPTH);
    localparam int LVL_W = lvl_w(ADDR_BITS);
    localparam int SUM_W = ((LVL_W > CNT_W) ? LVL_W : CNT_W) + 1;
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    typedef logic [SUM_W-1:0] sum_t;

    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [PIPE_MAX-1:0]   pipe_ext;
    logic [2:0]            inflight;
    logic                  skid_push;
    logic [CNT_W-1:0]      skid_count;
    logic [DATA_WIDTH-1:0] skid_head;
    logic                  accept;
    logic [15:0]           beat_cnt_q, beat_cnt_d;
    sum_t                  level_s, inflight_s, count_s;

    always_comb begin
        pipe_ext = '0;
        pipe_ext[RD_LATENCY-1:0] = pipe_q;
    end

    assign inflight   = popcount(pipe_ext);
    assign level_s    = sum_t'(fifo_level_i);
    assign inflight_s = sum_t'(inflight);
    assign count_s    = sum_t'(skid_count);

    // Level still counts reads younger than RD_LATENCY, and the skid must have room for every read in flight.
    assign fifo_rd_o = resetn_i && enable_i && (level_s > inflight_s)
                       && ((count_s + inflight_s) < sum_t'(SKID_DEPTH));

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = fifo_rd_o;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign skid_push = pipe_q[RD_LATENCY-1];

    skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk_i       (clk_i),
        .resetn_i    (resetn_i),
        .push_i      (skid_push),
        .push_data_i (fifo_data_i),
        .pop_i       (accept),
        .count_o     (skid_count),
        .head_o      (skid_head)
    );

    assign m_valid_o = (skid_count != '0);
    assign m_data_o  = skid_head;
    assign accept    = m_valid_o && m_ready_i;
    assign m_last_o  = m_valid_o && (beat_cnt_q == LAST_BEAT);
    assign idle_o    = (skid_count == '0) && (inflight == '0);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept) beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? 16'd0 : beat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pipe_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            pipe_q     <= pipe_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_READER_BEATCNT_EN
    logic [31:0] beat_total_q, beat_total_d;
    logic [15:0] pkt_total_q, pkt_total_d;

    always_comb begin
        beat_total_d = beat_total_q;
        pkt_total_d  = pkt_total_q;
        if (accept)             beat_total_d = beat_total_q + 32'd1;
        if (accept && m_last_o) pkt_total_d  = pkt_total_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            beat_total_q <= '0;
            pkt_total_q  <= '0;
        end else begin
            beat_total_q <= beat_total_d;
            pkt_total_q  <= pkt_total_d;
        end
    end

    assign beat_count_o = beat_total_q;
    assign pkt_count_o  = pkt_total_q;
`endif

endmodule
